// File: rtl/uart_pkg.sv
// Shared UART definitions: default sizes, parity encodings, the parity
// helper and the transmit scheduler state encoding.
package uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 868;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    // Callers zero-extend their payload, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [63:0] data,
                                         input logic       odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter handshake bundle of the UART tx scheduler.
// master: scheduler side (drives req_ready, tx_enable, tx_data);
// slave: environment side (drives req_valid, req_data, tx_busy).
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PARITY_ENABLED = 1
);
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]        req_data;
    logic [NUM_REQ-1:0]                   req_ready;
    logic                                 tx_enable;
    logic [DATA_WIDTH+PARITY_ENABLED-1:0] tx_data;
    logic                                 tx_busy;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_enable, tx_data
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_enable, tx_data
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud counter with a one-cycle tick on its last count.
// Ports: clk, reset (sync, active-high), tick (one cycle per period).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ sources.
// Ports: clk, reset (sync, active-high), bus (requester/transmitter
// handshake), tx_baud_clk, grant_id, frame_done, err_no_busy.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PARITY_ENABLED = 1,
    parameter int PARITY_ODD     = PAR_EVEN,
    parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_scheduler_if.master        bus,
    output logic                       tx_baud_clk,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done,
    output logic                       err_no_busy
);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int TXW = DATA_WIDTH + PARITY_ENABLED;
    localparam logic [GW:0]   NREQ = (GW + 1)'(NUM_REQ);
    localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

    state_t                state;
    logic [GW-1:0]         rr_ptr;
    logic                  wb_cnt;
    logic [TXW-1:0]        hold;
    logic                  found;
    logic [GW-1:0]         winner;
    logic [GW:0]           sum;
    logic                  accept;
    logic                  par;
    logic [DATA_WIDTH-1:0] win_data;
    logic [TXW-1:0]        hold_d;
    logic [DATA_WIDTH-1:0] slot [NUM_REQ];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (tx_baud_clk)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (GW + 1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && bus.req_valid[sum[GW-1:0]]) begin
                found  = 1'b1;
                winner = sum[GW-1:0];
            end
        end
    end

    assign win_data = slot[winner];
    assign par      = calc_parity(64'(win_data), PARITY_ODD != 0);

    if (PARITY_ENABLED != 0) begin : g_par
        assign hold_d = {par, win_data};
    end else begin : g_nopar
        assign hold_d = win_data;
    end

    // The accept pulse is the requester's handshake, so it must be seen
    // in the same cycle as the valid; reset masks it.
    assign accept = (state == IDLE) && found && !bus.tx_busy && !reset;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign bus.tx_data = hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            wb_cnt        <= 1'b0;
            hold          <= '0;
            grant_id      <= '0;
            bus.tx_enable <= 1'b0;
            frame_done    <= 1'b0;
            err_no_busy   <= 1'b0;
        end else begin
            bus.tx_enable <= 1'b0;
            frame_done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        hold          <= hold_d;
                        grant_id      <= winner;
                        rr_ptr        <= (winner == LAST) ? '0 : winner + 1'b1;
                        bus.tx_enable <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    wb_cnt <= 1'b0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Give the transmitter two cycles to raise busy.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wb_cnt) begin
                        err_no_busy <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wb_cnt <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: baud tick, round-robin, parity,
// missing-busy error and reset mid-frame, with a simple transmitter model.
module tb_uart_tx_scheduler;
    localparam int CPB      = 4;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       model_on;
    logic       baud, baud_o, fd, fd_o, err, err_o;
    logic [1:0] gid, gid_o;

    int checks   = 0;
    int failures = 0;

    int             cyc     = 0;
    int             n_done  = 0;
    int             n_en    = 0;
    int             bad_hot = 0;
    int             acc_q   [$];
    int             acc_cyc [$];
    logic [8:0]     en_q    [$];

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(8),
                           .PARITY_ENABLED(1)) bus ();
    uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(8),
                           .PARITY_ENABLED(1)) bus_o ();

    uart_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .PARITY_ENABLED(1),
        .PARITY_ODD(0), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tx_baud_clk(baud), .grant_id(gid),
        .frame_done(fd), .err_no_busy(err)
    );

    uart_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .PARITY_ENABLED(1),
        .PARITY_ODD(1), .CLKS_PER_BIT(CPB)
    ) dut_o (
        .clk(clk), .reset(reset), .bus(bus_o),
        .tx_baud_clk(baud_o), .grant_id(gid_o),
        .frame_done(fd_o), .err_no_busy(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (n_done >= target) break;
        end
        chk({tag, "_done_cnt"}, n_done, target);
    endtask

    // Transmitter model: busy for BUSY_LEN cycles after each load strobe.
    initial begin
        int cnt;
        cnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cnt = 0;
                bus.tx_busy = 1'b0;
            end else begin
                if (model_on && bus.tx_enable) cnt = BUSY_LEN;
                if (cnt > 0) begin
                    bus.tx_busy = 1'b1;
                    cnt--;
                end else begin
                    bus.tx_busy = 1'b0;
                end
            end
        end
    end

    // Event log of the main instance.
    initial begin
        forever begin
            int w;
            @(negedge clk);
            cyc++;
            w = -1;
            if (bus.req_ready != '0) begin
                if ($countones(bus.req_ready) != 1) bad_hot++;
                for (int i = 0; i < 4; i++) begin
                    if (bus.req_ready[i]) w = i;
                end
                acc_q.push_back(w);
                acc_cyc.push_back(cyc);
            end
            if (bus.tx_enable) begin
                n_en++;
                en_q.push_back(bus.tx_data);
            end
            if (fd) n_done++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] tmask;
        logic        any_act;
        int          exp_ord [5];
        logic [8:0]  exp_dat [5];
        exp_ord = '{0, 1, 2, 3, 0};
        exp_dat = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h011};

        reset           = 1'b1;
        model_on        = 1'b1;
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus_o.req_valid = '0;
        bus_o.req_data  = '0;
        bus_o.tx_busy   = 1'b0;

        // Reset values and idle baud ticks
        do_reset();
        tmask   = '0;
        any_act = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_en", bus.tx_enable, 0);
                chk("rst_data", bus.tx_data, 0);
                chk("rst_gid", gid, 0);
                chk("rst_done", fd, 0);
                chk("rst_err", err, 0);
                chk("rst_baud", baud, 0);
            end
            if (baud) tmask[i] = 1'b1;
            if (bus.req_ready != '0 || bus.tx_enable || fd) any_act = 1'b1;
        end
        chk("tick_pos", tmask, 12'h888);
        chk("idle_quiet", any_act, 0);

        // Single requester 2, 0xA5, even parity
        step();
        n_done = 0;
        n_en   = 0;
        bus.req_data  = 32'h00A5_0000;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_en", bus.tx_enable, 1);
        chk("single_data", bus.tx_data, 9'h0A5);
        chk("single_gid", gid, 2);
        chk("single_ready_off", bus.req_ready, 0);
        wait_done(1, "single");
        repeat (5) @(negedge clk);
        chk("single_done_once", n_done, 1);
        chk("single_en_once", n_en, 1);
        chk("single_gid_hold", gid, 2);

        // All four valid: round-robin order and spacing
        do_reset();
        acc_q.delete();
        acc_cyc.delete();
        en_q.delete();
        n_done  = 0;
        bad_hot = 0;
        bus.req_data  = 32'h4433_2211;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 400; k++) begin
            step();
            if (acc_q.size() >= 5) break;
        end
        bus.req_valid = '0;
        chk("rr_accepts", acc_q.size(), 5);
        wait_done(5, "rr");
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", (i < acc_q.size()) ? acc_q[i] : 99, exp_ord[i]);
            chk("rr_data", (i < en_q.size()) ? en_q[i] : 9'h1FF,
                exp_dat[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk("rr_gap", (i + 1 < acc_cyc.size()) ?
                acc_cyc[i+1] - acc_cyc[i] : 0, BUSY_LEN + 2);
        end
        chk("rr_onehot", bad_hot, 0);

        // Odd parity instance
        step();
        bus_o.req_data  = 32'h0000_0307;
        bus_o.req_valid = 4'b0001;
        @(negedge clk);
        chk("odd_ready0", bus_o.req_ready, 4'b0001);
        step();
        bus_o.req_valid = 4'b0010;
        @(negedge clk);
        chk("odd_07", bus_o.tx_data, 9'h007);
        chk("odd_hold_off", bus_o.req_ready, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            if (bus_o.req_ready != '0) break;
        end
        chk("odd_ready1", bus_o.req_ready, 4'b0010);
        step();
        bus_o.req_valid = '0;
        @(negedge clk);
        chk("odd_03", bus_o.tx_data, 9'h103);
        chk("odd_err", err_o, 1);

        // Transmitter never goes busy
        step();
        model_on      = 1'b0;
        bus.req_data  = 32'h0000_5A00;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("nb_ready", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("nb_en", bus.tx_enable, 1);
        step();
        @(negedge clk);
        chk("nb_err_wb1", err, 0);
        step();
        @(negedge clk);
        chk("nb_err_wb2", err, 0);
        step();
        bus.req_data  = 32'h7700_0000;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("nb_err", err, 1);
        chk("nb_next_ready", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("nb_next_data", bus.tx_data, 9'h077);
        repeat (6) step();
        model_on = 1'b1;
        @(negedge clk);
        chk("nb_sticky", err, 1);

        // Reset during WAIT_DONE
        step();
        bus.req_data  = 32'h003C_0000;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("rd_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        step();
        step();
        step();
        n_done = 0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rd_ready_off", bus.req_ready, 0);
        chk("rd_en", bus.tx_enable, 0);
        chk("rd_data0", bus.tx_data, 0);
        chk("rd_gid0", gid, 0);
        chk("rd_fd", fd, 0);
        chk("rd_err", err, 0);
        chk("rd_baud", baud, 0);
        repeat (15) @(negedge clk);
        chk("rd_no_done", n_done, 0);
        step();
        bus.req_data  = 32'h4433_2211;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("rd_ptr0", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rd_data", bus.tx_data, 9'h011);
        chk("rd_gid", gid, 0);
        wait_done(1, "rd_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter (start + data + optional parity + stop, LSB first) among NUM_REQ byte sources.
- Round-robin arbitration across requesters.
- Computes the parity bit.
- Generates the one-cycle baud tick.
- Sequences the transmitter's enable/busy handshake so exactly one frame is in flight at a time.
- Sits between the packet/command sources and the transmitter, in the same clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, payload bits per frame
PARITY_ENABLED, 1, 1 = append parity bit, 0 = no parity
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_ENABLED=0)
CLKS_PER_BIT, 868, clk cycles per baud tick (≥2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i in slice [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
tx_enable  out  1  load strobe to transmitter
tx_data  out  DATA_WIDTH+PARITY_ENABLED  {parity, data}
tx_busy  in  1  transmitter busy
tx_baud_clk  out  1  one-cycle baud tick
grant_id  out  clog2(NUM_REQ)  requester of current/last frame
frame_done  out  1  one-cycle pulse when the frame completes
err_no_busy  out  1  sticky: transmitter failed to go busy

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; baud counter = 0; FSM = IDLE. Reset mid-frame abandons the frame with no frame_done pulse; the transmitter shares the same reset.
- Baud generator:
  - Free-running counter 0..CLKS_PER_BIT-1.
  - tx_baud_clk=1 for exactly one cycle when count == CLKS_PER_BIT-1, then count wraps to 0.
  - Not gated by FSM state.
- Arbitration:
  - Priority order starts at rr pointer and wraps modulo NUM_REQ.
  - First requester with req_valid=1 wins.
  - On accept, pointer = winner+1 (wrapping NUM_REQ-1 → 0).
- FSM states:
  - IDLE: if any req_valid and tx_busy=0 → LOAD, same cycle:
    - req_ready[winner] = 1 (the handshake); requester must hold data/valid until then.
    - Latch req_data slice into holding reg.
    - grant_id = winner.
  - LOAD: tx_enable=1 for exactly this cycle; tx_data driven from holding reg (stable from LOAD until next accept) → WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1 → WAIT_DONE.
    - tx_busy still 0 after 2 cycles in this state → set err_no_busy (cleared only by reset) → IDLE.
  - WAIT_DONE: tx_busy 1→0 observed → frame_done=1 for one cycle → IDLE.
- Request rules:
  - No request is accepted while the FSM is outside IDLE.
  - No request is accepted in IDLE while tx_busy=1.
  - Min gap between accepts = frame time + 2 cycles.
- Parity:
  - Even parity = XOR of data bits; odd parity = inverted XOR.
  - tx_data MSB = parity; with PARITY_ENABLED=0, tx_data = data only.
- Simultaneous events:
  - Multiple valids → single grant per round-robin rule.
  - req_valid dropping before grant is permitted; that requester is not served.
  - baud tick coinciding with LOAD is harmless (tick is independent).
- grant_id holds its value until the next accept.

Decomposition:
- Shared package uart_pkg:
  - Constants: default DATA_WIDTH, CLKS_PER_BIT, PARITY_* encodings.
  - Function: parity calc.
  - FSM state enum: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- One sub-module: uart_baud_gen (counter + tick, parameter CLKS_PER_BIT). It is reused by the receive side at 16x oversampling.

Test Plan:
- Reset then idle 3*CLKS_PER_BIT (use CLKS_PER_BIT=4) → tx_baud_clk every 4th cycle; no req_ready, tx_enable, or frame_done.
- Single requester 2 sends 0xA5, even parity, with transmitter model attached → req_ready=0b0100 one cycle; tx_enable next cycle with tx_data=9'h0A5 (parity 0); frame_done once after tx_busy falls; grant_id=2.
- All 4 valid continuously, data 0x11/0x22/0x33/0x44 → frames emitted in order 0,1,2,3,0; each requester gets exactly one req_ready per accept; never two accepts within one frame.
- Odd parity, data 0x07 → tx_data=9'h007 (three ones → parity 0); data 0x03 → 9'h103.
- Transmitter model never raises busy → err_no_busy=1 two cycles after WAIT_BUSY entry; FSM back in IDLE; next request still accepted.
- Assert reset during WAIT_DONE → next cycle all outputs 0 and FSM IDLE; no frame_done pulse; rr pointer back to 0, so requester 0 wins next.
